zombie_round_ctrl: RTL
======================

Name: zombie_round_ctrl

Overview:
Game-engine stage for the Punch-Zombie board. It sits between the button conditioner and the LED/button display stage.
- Spawns a zombie in one of three holes using pseudo-random selection.
- Times the player's hit window and scores hits and misses.
- Tracks remaining lives.
- Drives the gameover level that the display stage consumes.

Parameters:
TICK_DIV, 25_000_000, clk cycles per game tick (benches use 4)
GAP_TICKS, 2, empty ticks between zombies
HIT_WINDOW, 8, initial ticks a zombie stays up
MIN_WINDOW, 2, floor for the shrinking window
LIVES, 3, lives at start of round (1..3)
WIN_SCORE, 20, score that ends the round as a win (≤31)
LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a round from IDLE or OVER
hit  in  3  [3:1] one-cycle press pulses, one per hole, already debounced
zombie  out  3  [3:1] one-hot active hole; 000 when none
score  out  5  hits this round
lives  out  2  remaining lives
gameover  out  1  high while in OVER
win  out  1  high in OVER when WIN_SCORE was reached

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values, applied on rst at any time including mid-round:
  - state=IDLE; zombie=000, score=0, lives=LIVES, gameover=0, win=0.
  - lfsr=LFSR_SEED, prescaler=0, window_len=HIT_WINDOW, prev_hole=none.
- All outputs are registered. A response to hit/start appears the cycle after the input is sampled.
- Prescaler:
  - Counts 0..TICK_DIV-1. tick is a one-cycle pulse when count==TICK_DIV-1.
  - Cleared to 0 on any state transition.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clk in every state, so press timing seeds it.
- Hole selection, performed on GAP→ACTIVE:
  - sel=lfsr[1:0]; 0→hole1, 1→hole2, 2→hole3, 3→hole1.
  - If sel equals prev_hole, use the next hole cyclically (1→2→3→1).
  - prev_hole updates to the chosen hole.
- States:
  - IDLE:
    - zombie=000.
    - start → GAP: score=0, lives=LIVES, window_len=HIT_WINDOW, win=0, gap counter=GAP_TICKS.
  - GAP:
    - hit is ignored.
    - Gap counter decrements on tick. On the tick that takes it 1→0: choose a hole, drive zombie one-hot, load window counter=window_len, go to ACTIVE.
  - ACTIVE, evaluated in this priority order:
    1. hit≠000 and (hit & ~zombie)≠000 (wrong hole, including correct+wrong in the same cycle) → miss.
    2. hit==zombie → good hit.
    3. tick with window counter==1 → miss (timeout).
    4. Otherwise, on tick, decrement the window counter.
    - A hit in the same cycle as the timeout tick counts as the hit.
  - Good hit:
    - score+1, zombie=000.
    - If the new score==WIN_SCORE → OVER with win=1.
    - Else → GAP.
    - Every 4th point (new score%4==0): window_len-1, floored at MIN_WINDOW.
  - Miss:
    - lives-1, zombie=000.
    - If the new lives==0 → OVER with win=0.
    - Else → GAP.
  - OVER:
    - gameover=1, zombie=000. score, lives and win are held.
    - hit is ignored.
    - start → GAP with the same initialisation as from IDLE; gameover drops the next cycle.
- start in GAP or ACTIVE is ignored.
- score saturates at 31; this is unreachable when WIN_SCORE≤31.

Decomposition:
- Shared package zombie_pkg holds:
  - the state enum {IDLE, GAP, ACTIVE, OVER};
  - hole one-hot constants HOLE1=3'b001, HOLE2=3'b010, HOLE3=3'b100, NONE=3'b000;
  - the LFSR tap mask.
- One sub-module, zombie_lfsr: 8-bit free-running LFSR with seed parameter and sync reset. Prescaler and FSM stay in the top module.

Test Plan:
1. Reset/start: TICK_DIV=4, GAP_TICKS=2, rst 2 cycles, start pulse → zombie one-hot exactly 8 clks after the first GAP cycle; score=0, lives=3, gameover=0.
2. Good hit: zombie=010, then hit=010 → next cycle zombie=000, score=1, state GAP; a repeat of 010 ignored in GAP, score stays 1.
3. Wrong/simultaneous: zombie=001, hit=011 → lives 3→2, score unchanged, zombie=000.
4. Timeout and tie: HIT_WINDOW=4, no hits → miss after 4 ticks. Repeat with hit==zombie on the exact timeout tick → score+1, lives unchanged.
5. Game over: three timeouts → lives=0, gameover=1, win=0, zombie stays 000; hits ignored; start → gameover=0 next cycle, lives=3, score=0.
6. Win and window shrink: WIN_SCORE=8, correct hits every zombie → window_len 8→7 at score 4 and 7→6 at score 8; OVER with win=1 and score=8. No hole is chosen twice consecutively in 8 spawns; rst mid-ACTIVE → IDLE with all reset values next cycle.

Source files
------------

// File: rtl/zombie_pkg.sv
// rtl/zombie_pkg.sv - shared types and constants for the zombie round controller
package zombie_pkg;

  typedef enum logic [1:0] {IDLE, GAP, ACTIVE, OVER} state_t;

  localparam logic [2:0] HOLE1 = 3'b001;
  localparam logic [2:0] HOLE2 = 3'b010;
  localparam logic [2:0] HOLE3 = 3'b100;
  localparam logic [2:0] NONE  = 3'b000;

  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // sel 3 folds onto hole 1; a repeat of the previous hole rotates to the next one
  function automatic logic [2:0] pick_hole(input logic [1:0] sel, input logic [2:0] prev);
    logic [2:0] h;
    case (sel)
      2'd1:    h = HOLE2;
      2'd2:    h = HOLE3;
      default: h = HOLE1;
    endcase
    if (h == prev) h = {h[1:0], h[2]};
    return h;
  endfunction

endpackage

// File: rtl/zombie_lfsr.sv
// rtl/zombie_lfsr.sv - free-running 8-bit Fibonacci LFSR with synchronous seed load
module zombie_lfsr
  import zombie_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] sel
);

  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  assign sel = lfsr[1:0];

endmodule

// File: rtl/zombie_round_ctrl.sv
// rtl/zombie_round_ctrl.sv - punch-zombie round engine: spawn, hit window, score and lives
module zombie_round_ctrl
  import zombie_pkg::*;
#(
  parameter int         TICK_DIV   = 25_000_000,
  parameter int         GAP_TICKS  = 2,
  parameter int         HIT_WINDOW = 8,
  parameter int         MIN_WINDOW = 2,
  parameter int         LIVES      = 3,
  parameter int         WIN_SCORE  = 20,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] hit,
  output logic [2:0] zombie,
  output logic [4:0] score,
  output logic [1:0] lives,
  output logic       gameover,
  output logic       win
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(HIT_WINDOW + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);

  state_t          state, state_n;
  logic [PW-1:0]   prescale;
  logic            tick;
  logic [WW-1:0]   window_len, wlen_n;
  logic [WW-1:0]   win_cnt, wcnt_n;
  logic [GW-1:0]   gap_cnt, gcnt_n;
  logic [2:0]      prev_hole, prev_n;
  logic [2:0]      zombie_n;
  logic [4:0]      score_n, new_score;
  logic [1:0]      lives_n, new_lives;
  logic            win_n;
  logic            do_hit, do_miss;
  logic [2:0]      hole;
  logic [1:0]      rnd;

  zombie_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .sel (rnd)
  );

  assign tick = (prescale == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      zombie     <= NONE;
      score      <= '0;
      lives      <= 2'(LIVES);
      gameover   <= 1'b0;
      win        <= 1'b0;
      window_len <= WW'(HIT_WINDOW);
      win_cnt    <= '0;
      gap_cnt    <= '0;
      prev_hole  <= NONE;
      prescale   <= '0;
    end else begin
      state      <= state_n;
      zombie     <= zombie_n;
      score      <= score_n;
      lives      <= lives_n;
      gameover   <= (state_n == OVER);
      win        <= win_n;
      window_len <= wlen_n;
      win_cnt    <= wcnt_n;
      gap_cnt    <= gcnt_n;
      prev_hole  <= prev_n;
      // every state change restarts the tick phase so windows are whole ticks
      prescale   <= (state_n != state || tick) ? '0 : prescale + PW'(1);
    end
  end

  always_comb begin
    state_n   = state;
    zombie_n  = zombie;
    score_n   = score;
    lives_n   = lives;
    win_n     = win;
    wlen_n    = window_len;
    wcnt_n    = win_cnt;
    gcnt_n    = gap_cnt;
    prev_n    = prev_hole;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    hole      = pick_hole(rnd, prev_hole);
    new_score = (score == 5'd31) ? score : score + 5'd1;
    new_lives = lives - 2'd1;

    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n = GAP;
          score_n = '0;
          lives_n = 2'(LIVES);
          wlen_n  = WW'(HIT_WINDOW);
          win_n   = 1'b0;
          gcnt_n  = GW'(GAP_TICKS);
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt == GW'(1)) begin
            zombie_n = hole;
            prev_n   = hole;
            wcnt_n   = window_len;
            state_n  = ACTIVE;
          end else begin
            gcnt_n = gap_cnt - GW'(1);
          end
        end
      end
      ACTIVE: begin
        // a wrong press beats a simultaneous correct one; a correct press beats the timeout
        if (hit != NONE && (hit & ~zombie) != NONE) do_miss = 1'b1;
        else if (hit == zombie)                     do_hit  = 1'b1;
        else if (tick && win_cnt == WW'(1))         do_miss = 1'b1;
        else if (tick)                              wcnt_n  = win_cnt - WW'(1);
      end
      default: state_n = IDLE;
    endcase

    if (do_hit) begin
      score_n  = new_score;
      zombie_n = NONE;
      gcnt_n   = GW'(GAP_TICKS);
      if (new_score == 5'(WIN_SCORE)) begin
        state_n = OVER;
        win_n   = 1'b1;
      end else begin
        state_n = GAP;
      end
      if (new_score[1:0] == 2'd0 && window_len > WW'(MIN_WINDOW))
        wlen_n = window_len - WW'(1);
    end

    if (do_miss) begin
      lives_n  = new_lives;
      zombie_n = NONE;
      gcnt_n   = GW'(GAP_TICKS);
      if (new_lives == 2'd0) begin
        state_n = OVER;
        win_n   = 1'b0;
      end else begin
        state_n = GAP;
      end
    end
  end

endmodule
